// File: rtl/execute_muldiv.sv
// RV32 execute stage: forwarding muxes, single-cycle ALU/branch/jump-target path,
// and an iterative radix-2 M-extension unit that stalls the front of the pipeline.

// Single-cycle integer ALU with branch-condition evaluation.
module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            alu_ctrl,
  input  logic [2:0]            branch_src,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_taken
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt_s;
  logic           lt_s;
  logic           ltu_s;
  logic           eq_s;

  assign shamt_s = b[SHW-1:0];
  assign lt_s    = ($signed(a) < $signed(b));
  assign ltu_s   = (a < b);
  assign eq_s    = (a == b);

  // Arithmetic / logic result selection.
  always_comb begin
    result = {DATA_WIDTH{1'b0}};
    case (alu_ctrl)
      4'b0000: result = a + b;
      4'b0001: result = a - b;
      4'b0010: result = a & b;
      4'b0011: result = a | b;
      4'b0100: result = a ^ b;
      4'b0101: result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      4'b0110: result = {{(DATA_WIDTH-1){1'b0}}, ltu_s};
      4'b0111: result = a << shamt_s;
      4'b1000: result = a >> shamt_s;
      4'b1001: result = $unsigned($signed(a) >>> shamt_s);
      4'b1010: result = b;
      default: result = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Branch condition evaluation on the two ALU operands.
  always_comb begin
    branch_taken = 1'b0;
    case (branch_src)
      3'b000:  branch_taken = 1'b0;
      3'b001:  branch_taken = eq_s;
      3'b010:  branch_taken = ~eq_s;
      3'b011:  branch_taken = lt_s;
      3'b100:  branch_taken = ~lt_s;
      3'b101:  branch_taken = ltu_s;
      3'b110:  branch_taken = ~ltu_s;
      3'b111:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end
endmodule

module execute_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RD1E_i,
  input  logic [DATA_WIDTH-1:0] RD2E_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] ImmExtE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
  input  logic [3:0]            ALUCtrl_i,
  input  logic                  ALUSrcA_i,
  input  logic                  ALUSrcB_i,
  input  logic                  JumpCtrl_i,
  input  logic [2:0]            BranchSrc_i,
  input  logic [4:0]            RdD_i,
  input  logic [1:0]            ForwardAE_i,
  input  logic [1:0]            ForwardBE_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic                  ValidE_i,
  input  logic                  MulDivEn_i,
  input  logic [2:0]            MulDivOp_i,
  input  logic                  FlushE_i,
  output logic [DATA_WIDTH-1:0] ALUResultE_o,
  output logic [DATA_WIDTH-1:0] WriteDataE_o,
  output logic [DATA_WIDTH-1:0] PCPlus4E_o,
  output logic [DATA_WIDTH-1:0] PCTargetE_o,
  output logic [4:0]            RdE_o,
  output logic                  branchTaken_o,
  output logic                  StallE_o,
  output logic                  MulDivDoneE_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // ---------------- single-cycle path ----------------
  logic [1:0]   fwd_a_sel_s;
  logic [1:0]   fwd_b_sel_s;
  logic [W-1:0] fwd_a_s;
  logic [W-1:0] fwd_b_s;
  logic [W-1:0] src_a_s;
  logic [W-1:0] src_b_s;
  logic [W-1:0] alu_result_s;
  logic         alu_branch_s;

  assign fwd_a_sel_s = FWD_EN ? ForwardAE_i : 2'b00;
  assign fwd_b_sel_s = FWD_EN ? ForwardBE_i : 2'b00;

  // Forwarding muxes: 01 takes the writeback value, 10 the memory-stage result.
  always_comb begin
    fwd_a_s = RD1E_i;
    fwd_b_s = RD2E_i;
    case (fwd_a_sel_s)
      2'b01:   fwd_a_s = ResultW_i;
      2'b10:   fwd_a_s = ALUResultM_i;
      default: fwd_a_s = RD1E_i;
    endcase
    case (fwd_b_sel_s)
      2'b01:   fwd_b_s = ResultW_i;
      2'b10:   fwd_b_s = ALUResultM_i;
      default: fwd_b_s = RD2E_i;
    endcase
  end

  assign src_a_s = ALUSrcA_i ? PCE_i : fwd_a_s;
  assign src_b_s = ALUSrcB_i ? ImmExtE_i : fwd_b_s;

  alu #(.DATA_WIDTH(W)) u_alu (
    .a            (src_a_s),
    .b            (src_b_s),
    .alu_ctrl     (ALUCtrl_i),
    .branch_src   (BranchSrc_i),
    .result       (alu_result_s),
    .branch_taken (alu_branch_s)
  );

  assign WriteDataE_o  = fwd_b_s;
  assign PCPlus4E_o    = PCPlus4E_i;
  assign RdE_o         = RdD_i;
  assign branchTaken_o = alu_branch_s;
  assign PCTargetE_o   = JumpCtrl_i ? alu_result_s : (PCE_i + ImmExtE_i);

  // ---------------- operand decode at capture ----------------
  logic         start_s;
  logic         a_signed_s;
  logic         b_signed_s;
  logic         a_neg_s;
  logic         b_neg_s;
  logic [W-1:0] a_mag_s;
  logic [W-1:0] b_mag_s;
  logic         neg_s;
  logic         div_zero_s;
  logic         div_ovf_s;
  logic [W-1:0] special_val_s;

  assign start_s = ValidE_i & MulDivEn_i & ~FlushE_i;

  // Per-op operand signedness, magnitudes, result sign and RISC-V special cases.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (MulDivOp_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'b010: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s = a_signed_s & fwd_a_s[W-1];
    b_neg_s = b_signed_s & fwd_b_s[W-1];
    a_mag_s = a_neg_s ? (~fwd_a_s + {{(W-1){1'b0}}, 1'b1}) : fwd_a_s;
    b_mag_s = b_neg_s ? (~fwd_b_s + {{(W-1){1'b0}}, 1'b1}) : fwd_b_s;
    // Remainder takes the dividend's sign; everything else the product/quotient sign.
    if (MulDivOp_i[2] & MulDivOp_i[1]) begin
      neg_s = a_neg_s;
    end else begin
      neg_s = a_neg_s ^ b_neg_s;
    end
    div_zero_s = MulDivOp_i[2] & (fwd_b_s == {W{1'b0}});
    div_ovf_s  = MulDivOp_i[2] & ~MulDivOp_i[0] &
                 (fwd_a_s == MOST_NEG) & (fwd_b_s == ALL_ONES);
    if (div_zero_s) begin
      special_val_s = MulDivOp_i[1] ? fwd_a_s : ALL_ONES;
    end else begin
      special_val_s = MulDivOp_i[1] ? {W{1'b0}} : MOST_NEG;
    end
  end

  // ---------------- iterative datapath ----------------
  state_t       state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]   op_r;
  logic [W-1:0] a_mag_r;
  logic [W-1:0] b_mag_r;
  logic         neg_r;
  logic         special_r;
  logic [W-1:0] special_val_r;
  logic [W-1:0] hi_r;
  logic [W-1:0] lo_r;
  logic [W-1:0] result_r;

  logic [W:0]     mul_sum_s;
  logic [W:0]     rem_sh_s;
  logic [W:0]     diff_s;
  logic [W-1:0]   hi_nxt_s;
  logic [W-1:0]   lo_nxt_s;
  logic [2*W-1:0] prod_fix_s;
  logic [W-1:0]   quo_fix_s;
  logic [W-1:0]   rem_fix_s;
  logic [W-1:0]   final_s;

  // One radix-2 step: shift-add multiply (hi:lo = product) or restoring divide
  // (hi = partial remainder, lo = quotient shifting in over the dividend).
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_mag_r} : {(W+1){1'b0}});
    rem_sh_s  = {hi_r, lo_r[W-1]};
    diff_s    = rem_sh_s - {1'b0, b_mag_r};
    if (op_r[2]) begin
      if (!diff_s[W]) begin
        hi_nxt_s = diff_s[W-1:0];
        lo_nxt_s = {lo_r[W-2:0], 1'b1};
      end else begin
        hi_nxt_s = rem_sh_s[W-1:0];
        lo_nxt_s = {lo_r[W-2:0], 1'b0};
      end
    end else begin
      hi_nxt_s = mul_sum_s[W:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[W-1:1]};
    end
  end

  // Sign correction and special-case substitution applied on the last step.
  always_comb begin
    prod_fix_s = neg_r ? (~{hi_nxt_s, lo_nxt_s} + {{(2*W-1){1'b0}}, 1'b1})
                       : {hi_nxt_s, lo_nxt_s};
    quo_fix_s  = neg_r ? (~lo_nxt_s + {{(W-1){1'b0}}, 1'b1}) : lo_nxt_s;
    rem_fix_s  = neg_r ? (~hi_nxt_s + {{(W-1){1'b0}}, 1'b1}) : hi_nxt_s;
    if (special_r) begin
      final_s = special_val_r;
    end else if (op_r[2]) begin
      final_s = op_r[1] ? rem_fix_s : quo_fix_s;
    end else if (op_r[1:0] == 2'b00) begin
      final_s = prod_fix_s[W-1:0];
    end else begin
      final_s = prod_fix_s[2*W-1:W];
    end
  end

  // Mul/div control FSM: capture operands, iterate DATA_WIDTH steps, present result once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CW{1'b0}};
      op_r          <= 3'b000;
      a_mag_r       <= {W{1'b0}};
      b_mag_r       <= {W{1'b0}};
      neg_r         <= 1'b0;
      special_r     <= 1'b0;
      special_val_r <= {W{1'b0}};
      hi_r          <= {W{1'b0}};
      lo_r          <= {W{1'b0}};
      result_r      <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            op_r          <= MulDivOp_i;
            a_mag_r       <= a_mag_s;
            b_mag_r       <= b_mag_s;
            neg_r         <= neg_s;
            special_r     <= div_zero_s | div_ovf_s;
            special_val_r <= special_val_s;
            hi_r          <= {W{1'b0}};
            lo_r          <= MulDivOp_i[2] ? a_mag_s : b_mag_s;
            cnt_r         <= CW'(W);
            state_r       <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (FlushE_i) begin
            state_r <= ST_IDLE;
          end else begin
            hi_r  <= hi_nxt_s;
            lo_r  <= lo_nxt_s;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
              result_r <= final_s;
              state_r  <= ST_DONE;
            end else begin
              state_r <= ST_BUSY;
            end
          end
        end
        ST_DONE: begin
          // ID/EX advances on this edge, so never linger here.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall, done and result steering toward EX/MEM.
  always_comb begin
    StallE_o      = 1'b0;
    MulDivDoneE_o = 1'b0;
    ALUResultE_o  = alu_result_s;
    case (state_r)
      ST_IDLE: begin
        StallE_o = start_s;
      end
      ST_BUSY: begin
        StallE_o = ~FlushE_i;
      end
      ST_DONE: begin
        MulDivDoneE_o = ~FlushE_i;
        if (!FlushE_i) begin
          ALUResultE_o = result_r;
        end else begin
          ALUResultE_o = alu_result_s;
        end
      end
      default: begin
        StallE_o = 1'b0;
      end
    endcase
  end
endmodule
